// File: rtl/tss_pkg.sv
// rtl/tss_pkg.sv - shared state type and LLKI constants for the TSS key scanner
package tss_pkg;

    localparam int LLKI_WORD_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SCAN         = 2'd1,
        LOADED       = 2'd2,
        PARTIAL_LOAD = 2'd3
    } TSS_STATE_TYPE;

endpackage

// File: rtl/tss_key_shift_reg.sv
// rtl/tss_key_shift_reg.sv - wide key shift register, serial slice in at the MSB end, parallel out
module tss_key_shift_reg #(
    parameter int TOT        = 256,
    parameter int SHIFT_BITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_shift_en,
    input  logic                  i_clear,
    input  logic [SHIFT_BITS-1:0] i_serial_in,
    output logic [TOT-1:0]        o_q
);

    logic [TOT-1:0] r_q;

    // Right shift: after TOT/SHIFT_BITS shifts the first slice sits at bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= {i_serial_in, r_q[TOT-1:SHIFT_BITS]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/tss_key_scanner.sv
// rtl/tss_key_scanner.sv - LLKI TSS key loader: word handshake, serial scan, gated key to locked core
module tss_key_scanner
    import tss_pkg::*;
#(
    parameter int KEY_WIDTH  = 256,
    parameter int WORD_WIDTH = LLKI_WORD_WIDTH,
    parameter int SHIFT_BITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] llkid_key_data,
    input  logic                  llkid_key_valid,
    output logic                  llkid_key_ready,
    output logic                  llkid_key_complete,
    input  logic                  llkid_clear_key,
    output logic                  llkid_clear_key_ack,
    output logic [KEY_WIDTH-1:0]  core_key,
    output logic                  key_error
);

    localparam int NUM_WORDS = (KEY_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int TOT       = NUM_WORDS * WORD_WIDTH;
    localparam int SHIFTS    = WORD_WIDTH / SHIFT_BITS;
    localparam int CW        = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
    localparam int NW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    generate
        if ((WORD_WIDTH % SHIFT_BITS) != 0) begin : g_bad_shift
            $error("tss_key_scanner: SHIFT_BITS must divide WORD_WIDTH");
        end
    endgenerate

    TSS_STATE_TYPE         r_state;
    TSS_STATE_TYPE         w_state_nxt;
    logic [WORD_WIDTH-1:0] r_word;
    logic [CW-1:0]         r_cnt;
    logic [NW-1:0]         r_word_n;
    logic                  r_ready;
    logic                  r_complete;
    logic                  r_ack;
    logic                  r_error;

    logic                  w_ready_nxt;
    logic                  w_complete_nxt;
    logic                  w_error_nxt;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_last_word;
    logic                  w_shift_en;
    logic                  w_sr_clear;
    logic [TOT-1:0]        w_sr_q;

    assign w_accept    = llkid_key_valid && r_ready && (r_state != SCAN);
    assign w_last      = (r_state == SCAN) && (r_cnt == CW'(SHIFTS - 1));
    assign w_last_word = (r_word_n == NW'(NUM_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear outranks both a new word and the end-of-word transition.
    always_comb begin
        w_state_nxt    = r_state;
        w_ready_nxt    = r_ready;
        w_complete_nxt = r_complete;
        w_error_nxt    = r_error;
        w_shift_en     = 1'b0;
        w_sr_clear     = 1'b0;
        if (llkid_clear_key) begin
            w_state_nxt    = IDLE;
            w_ready_nxt    = 1'b1;
            w_complete_nxt = 1'b0;
            w_error_nxt    = 1'b0;
            w_sr_clear     = 1'b1;
        end else begin
            if (llkid_key_valid && !r_ready) begin
                w_error_nxt = 1'b1;
            end
            case (r_state)
                SCAN: begin
                    w_shift_en = 1'b1;
                    if (w_last) begin
                        w_ready_nxt = 1'b1;
                        if (w_last_word) begin
                            w_state_nxt    = LOADED;
                            w_complete_nxt = 1'b1;
                        end else begin
                            w_state_nxt = PARTIAL_LOAD;
                        end
                    end
                end
                default: begin
                    if (w_accept) begin
                        w_state_nxt    = SCAN;
                        w_ready_nxt    = 1'b0;
                        w_complete_nxt = 1'b0;
                        w_sr_clear     = (r_state == LOADED);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word     <= '0;
            r_cnt      <= '0;
            r_word_n   <= '0;
            r_ready    <= 1'b1;
            r_complete <= 1'b0;
            r_ack      <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_ready    <= w_ready_nxt;
            r_complete <= w_complete_nxt;
            r_error    <= w_error_nxt;
            r_ack      <= llkid_clear_key;
            if (llkid_clear_key) begin
                r_word   <= '0;
                r_cnt    <= '0;
                r_word_n <= '0;
            end else if (w_accept) begin
                r_word <= llkid_key_data;
                r_cnt  <= '0;
                if (r_state == LOADED) begin
                    r_word_n <= '0;
                end
            end else if (w_shift_en) begin
                r_word <= r_word >> SHIFT_BITS;
                if (w_last) begin
                    r_cnt    <= '0;
                    r_word_n <= w_last_word ? '0 : r_word_n + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    tss_key_shift_reg #(
        .TOT        (TOT),
        .SHIFT_BITS (SHIFT_BITS)
    ) u_shift_reg (
        .clk         (clk),
        .rst         (rst),
        .i_shift_en  (w_shift_en),
        .i_clear     (w_sr_clear),
        .i_serial_in (r_word[SHIFT_BITS-1:0]),
        .o_q         (w_sr_q)
    );

    generate
        if (KEY_WIDTH < TOT) begin : g_drop_hi
            logic w_unused_hi;
            assign w_unused_hi = ^w_sr_q[TOT-1:KEY_WIDTH];
        end
    endgenerate

    // r_complete is high exactly while LOADED, so it doubles as the registered key gate.
    assign core_key            = r_complete ? w_sr_q[KEY_WIDTH-1:0] : '0;
    assign llkid_key_ready     = r_ready;
    assign llkid_key_complete  = r_complete;
    assign llkid_clear_key_ack = r_ack;
    assign key_error           = r_error;

endmodule

// File: tb/tb_tss_key_scanner.sv
// tb/tb_tss_key_scanner.sv - randomized self-checking bench for tss_key_scanner with a word-list key model
module tb_tss_key_scanner;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  data;
    logic         valid;
    logic         clr;
    logic         ready, complete, ack, err;
    logic [255:0] core_key;

    logic [63:0]  data2;
    logic         valid2;
    logic         clr2;
    logic         ready2, complete2, ack2, err2;
    logic [99:0]  core_key2;

    int           n_tests = 0;
    int           n_fail  = 0;

    logic [63:0]  m_words [4];
    int           m_count = 0;

    always #5 clk = ~clk;

    tss_key_scanner dut (
        .clk                 (clk),
        .rst                 (rst),
        .llkid_key_data      (data),
        .llkid_key_valid     (valid),
        .llkid_key_ready     (ready),
        .llkid_key_complete  (complete),
        .llkid_clear_key     (clr),
        .llkid_clear_key_ack (ack),
        .core_key            (core_key),
        .key_error           (err)
    );

    tss_key_scanner #(
        .KEY_WIDTH  (100),
        .WORD_WIDTH (64),
        .SHIFT_BITS (8)
    ) dut2 (
        .clk                 (clk),
        .rst                 (rst),
        .llkid_key_data      (data2),
        .llkid_key_valid     (valid2),
        .llkid_key_ready     (ready2),
        .llkid_key_complete  (complete2),
        .llkid_clear_key     (clr2),
        .llkid_clear_key_ack (ack2),
        .core_key            (core_key2),
        .key_error           (err2)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] model_key();
        logic [255:0] k;
        k = '0;
        if (m_count == 4) begin
            for (int i = 0; i < 4; i++) k[64*i +: 64] = m_words[i];
        end
        return k;
    endfunction

    task automatic model_push(input logic [63:0] w);
        if (m_count == 4) m_count = 0;
        m_words[m_count] = w;
        m_count++;
    endtask

    task automatic check_key(input string tag);
        check({tag, " complete"}, complete, (m_count == 4) ? 1 : 0);
        check({tag, " core_key"}, core_key, model_key());
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        check({tag, " ready_wait"}, ready, 1);
    endtask

    // glitch > 0 raises valid for one cycle that many edges after the accept edge.
    task automatic load_word(input logic [63:0] w, input int glitch, input string tag);
        int n;
        wait_ready(tag);
        data  = w;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        model_push(w);
        check({tag, " post_accept_key"}, core_key, 0);
        check({tag, " post_accept_cmp"}, complete, 0);
        check({tag, " post_accept_rdy"}, ready, 0);
        n = 1;
        while (!ready && n < 200) begin
            if (n == glitch) begin
                valid = 1'b1;
                data  = {$urandom, $urandom};
            end
            tick();
            valid = 1'b0;
            n++;
        end
        check({tag, " latency"}, n, 65);
        check_key(tag);
    endtask

    task automatic do_clear(input int cycles, input string tag);
        clr = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            tick();
            check({tag, " ack"}, ack, 1);
        end
        clr = 1'b0;
        m_count = 0;
        check({tag, " ready"}, ready, 1);
        check({tag, " err"}, err, 0);
        check_key(tag);
        tick();
        check({tag, " ack_drop"}, ack, 0);
    endtask

    initial begin
        logic [63:0]  w2 [2];
        logic [127:0] exp2;
        int           n;

        rst = 1'b1; valid = 1'b0; clr = 1'b0; data = '0;
        valid2 = 1'b0; clr2 = 1'b0; data2 = '0;
        repeat (3) tick();
        check("rst ready", ready, 1);
        check("rst complete", complete, 0);
        check("rst ack", ack, 0);
        check("rst err", err, 0);
        check("rst core_key", core_key, 0);
        rst = 1'b0;
        tick();

        // Narrow-key instance: 8 bits per cycle, top 28 bits of the second word dropped.
        for (int k = 0; k < 2; k++) begin
            w2[k]  = {$urandom, $urandom};
            data2  = w2[k];
            valid2 = 1'b1;
            tick();
            valid2 = 1'b0;
            n = 1;
            while (!ready2 && n < 100) begin
                tick();
                n++;
            end
            check("d2 latency", n, 9);
            check("d2 complete", complete2, (k == 1) ? 1 : 0);
        end
        exp2 = {w2[1], w2[0]};
        check("d2 core_key", core_key2, exp2[99:0]);
        check("d2 err", err2, 0);

        load_word(64'h1, 0, "dir w0");
        load_word(64'h2, 0, "dir w1");
        load_word(64'h3, 0, "dir w2");
        load_word(64'h4, 0, "dir w3");
        check("dir literal key", core_key,
              {4'h4, 60'h0, 4'h3, 60'h0, 4'h2, 60'h0, 4'h1});

        // Fresh keys pushed straight from LOADED, with random idle gaps between words.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                load_word({$urandom, $urandom}, 0, "rnd");
            end
        end

        // Clear on the 30th scan cycle of word 2.
        load_word({$urandom, $urandom}, 0, "clr30 w0");
        load_word({$urandom, $urandom}, 0, "clr30 w1");
        wait_ready("clr30 w2");
        data  = {$urandom, $urandom};
        valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (29) tick();
        check("clr30 in_scan", ready, 0);
        do_clear(1, "clr30");
        for (int i = 0; i < 4; i++) load_word({$urandom, $urandom}, 0, "reload");

        do_clear(3, "clr_hold");

        // Stray word during scan: flagged, ignored, sticky until clear.
        load_word({$urandom, $urandom}, 0, "err w0");
        load_word({$urandom, $urandom}, $urandom_range(2, 60), "err w1");
        check("err set", err, 1);
        load_word({$urandom, $urandom}, 0, "err w2");
        load_word({$urandom, $urandom}, 0, "err w3");
        check("err sticky", err, 1);
        do_clear(1, "err_clr");

        // Asynchronous reset from LOADED and from mid-scan.
        for (int i = 0; i < 4; i++) load_word({$urandom, $urandom}, 0, "pre_rst");
        #2 rst = 1'b1;
        #1;
        check("arst loaded key", core_key, 0);
        check("arst loaded cmp", complete, 0);
        tick();
        rst = 1'b0;
        m_count = 0;
        tick();
        load_word({$urandom, $urandom}, 0, "mid w0");
        wait_ready("mid w1");
        data  = {$urandom, $urandom};
        valid = 1'b1;
        tick();
        valid = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("arst scan ready", ready, 1);
        check("arst scan cmp", complete, 0);
        check("arst scan err", err, 0);
        check("arst scan ack", ack, 0);
        check("arst scan key", core_key, 0);
        tick();
        rst = 1'b0;
        m_count = 0;
        tick();
        check_key("post_rst idle");
        for (int i = 0; i < 4; i++) load_word({$urandom, $urandom}, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
